// File: rtl/time_counter.sv
// ============================================================================
//  Module      : time_counter
//  Description : MM:SS BCD time-of-run counter with one-second prescaler,
//                minute-advance input and a free-running display refresh strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_counter #(
  parameter int TICK_DIV    = 100_000_000,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clear,
  input  logic       inc_min,
  output logic [3:0] seg0,
  output logic [3:0] seg1,
  output logic [3:0] seg2,
  output logic [3:0] seg3,
  output logic       refresh,
  output logic       sec_tick,
  output logic       wrap
);

  localparam int c_PCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_RCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_PCNT_W-1:0] c_PCNT_MAX = c_PCNT_W'(TICK_DIV - 1);
  localparam logic [c_PCNT_W-1:0] c_PCNT_ONE = c_PCNT_W'(1);
  localparam logic [c_RCNT_W-1:0] c_RCNT_MAX = c_RCNT_W'(REFRESH_DIV - 1);
  localparam logic [c_RCNT_W-1:0] c_RCNT_ONE = c_RCNT_W'(1);

  logic [c_PCNT_W-1:0] r_pcnt;
  logic [c_RCNT_W-1:0] r_rcnt;
  logic [7:0]          r_sec;
  logic [7:0]          r_min;
  logic                r_refresh;
  logic                r_sec_tick;
  logic                r_wrap;

  logic                w_tick;
  logic                w_min_carry;
  logic                w_time_wrap;
  logic [7:0]          w_sec_next;
  logic [7:0]          w_min_p1;
  logic [7:0]          w_min_p2;
  logic [7:0]          w_min_next;

  // {tens, units} BCD increment, modulo 60.
  function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd5) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
      r[7:4] = v[7:4];
    end
    return r;
  endfunction

  assign w_tick      = run && (r_pcnt == c_PCNT_MAX);
  assign w_min_carry = w_tick && (r_sec == 8'h59);
  assign w_time_wrap = w_min_carry && (r_min == 8'h59);
  assign w_sec_next  = w_tick ? inc_bcd60(r_sec) : r_sec;
  assign w_min_p1    = inc_bcd60(r_min);
  assign w_min_p2    = inc_bcd60(w_min_p1);

  // A seconds carry and an inc_min pulse on the same edge add two minutes.
  always_comb begin
    w_min_next = r_min;
    case ({w_min_carry, inc_min})
      2'b11:          w_min_next = w_min_p2;
      2'b10, 2'b01:   w_min_next = w_min_p1;
      default:        w_min_next = r_min;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt     <= '0;
      r_rcnt     <= '0;
      r_sec      <= 8'h00;
      r_min      <= 8'h00;
      r_refresh  <= 1'b0;
      r_sec_tick <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_rcnt    <= (r_rcnt == c_RCNT_MAX) ? '0 : r_rcnt + c_RCNT_ONE;
      r_refresh <= (r_rcnt == c_RCNT_MAX);

      if (clear) begin
        r_pcnt     <= '0;
        r_sec      <= 8'h00;
        r_min      <= 8'h00;
        r_sec_tick <= 1'b0;
        r_wrap     <= 1'b0;
      end else begin
        if (run) begin
          r_pcnt <= w_tick ? '0 : r_pcnt + c_PCNT_ONE;
        end
        r_sec      <= w_sec_next;
        r_min      <= w_min_next;
        r_sec_tick <= w_tick;
        r_wrap     <= w_time_wrap;
      end
    end
  end

  assign seg0     = r_sec[3:0];
  assign seg1     = r_sec[7:4];
  assign seg2     = r_min[3:0];
  assign seg3     = r_min[7:4];
  assign refresh  = r_refresh;
  assign sec_tick = r_sec_tick;
  assign wrap     = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_time_counter.sv
// ============================================================================
//  Module      : tb_time_counter
//  Description : Directed self-checking bench for time_counter
//                (TICK_DIV=4, REFRESH_DIV=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_counter;

  logic        ck = 1'b0;
  logic        rst_n;
  logic        run;
  logic        clear;
  logic        inc_min;
  logic [3:0]  seg0, seg1, seg2, seg3;
  logic        refresh, sec_tick, wrap;
  logic [15:0] w_now;

  int total  = 0;
  int bad    = 0;
  int n_edge = 0;

  time_counter #(.TICK_DIV(4), .REFRESH_DIV(3)) dut (
    .ck       (ck),
    .rst_n    (rst_n),
    .run      (run),
    .clear    (clear),
    .inc_min  (inc_min),
    .seg0     (seg0),
    .seg1     (seg1),
    .seg2     (seg2),
    .seg3     (seg3),
    .refresh  (refresh),
    .sec_tick (sec_tick),
    .wrap     (wrap)
  );

  assign w_now = {seg3, seg2, seg1, seg0};

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then return on the falling edge to sample and drive.
  task automatic edge1();
    @(posedge ck);
    @(negedge ck);
    n_edge++;
  endtask

  task automatic run_edges(input int n);
    repeat (n) edge1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1; run = 1'b1; clear = 1'b0; inc_min = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_time", w_now, 16'h0000);
    chk("rst_async_refresh", refresh, 1'b0);
    chk("rst_async_sec_tick", sec_tick, 1'b0);
    chk("rst_async_wrap", wrap, 1'b0);
    run_edges(2);
    chk("rst_hold_time", w_now, 16'h0000);

    // Release with run=1: ticks on edges 4,8,12; refresh on 3,6,9,12.
    rst_n  = 1'b1;
    n_edge = 0;
    for (int k = 1; k <= 12; k++) begin
      edge1();
      chk("start_sec_tick", sec_tick, (k % 4 == 0));
      chk("start_refresh", refresh, (k % 3 == 0));
      chk("start_seg0", seg0, k / 4);
      chk("start_wrap", wrap, 1'b0);
    end

    // Preload 59:58, minute wrap via inc_min must not raise wrap.
    clear = 1'b1; run = 1'b0;
    edge1();
    clear = 1'b0;
    chk("clear_time", w_now, 16'h0000);
    chk("clear_sec_tick", sec_tick, 1'b0);
    inc_min = 1'b1;
    run_edges(59);
    chk("inc59_time", w_now, 16'h5900);
    edge1();
    chk("inc_wrap_time", w_now, 16'h0000);
    chk("inc_wrap_no_wrap", wrap, 1'b0);
    run_edges(59);
    inc_min = 1'b0;
    chk("inc59b_time", w_now, 16'h5900);
    run = 1'b1;
    run_edges(232);
    chk("pre_wrap_time", w_now, 16'h5958);
    chk("pre_wrap_sec_tick", sec_tick, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      edge1();
      chk("wrap_seq_wrap", wrap, (k == 8));
      chk("wrap_seq_sec_tick", sec_tick, (k % 4 == 0));
      if (k == 4) chk("wrap_seq_5959", w_now, 16'h5959);
    end
    chk("wrap_time", w_now, 16'h0000);
    edge1();
    chk("wrap_one_cycle", wrap, 1'b0);
    chk("wrap_after_sec_tick", sec_tick, 1'b0);

    // 00:59 plus inc_min on the tick edge gives 02:00 without wrap.
    clear = 1'b1; run = 1'b0;
    edge1();
    clear = 1'b0; run = 1'b1;
    run_edges(236);
    chk("t0059_time", w_now, 16'h0059);
    run_edges(3);
    inc_min = 1'b1;
    edge1();
    inc_min = 1'b0;
    chk("dbl_min_time", w_now, 16'h0200);
    chk("dbl_min_wrap", wrap, 1'b0);
    chk("dbl_min_sec_tick", sec_tick, 1'b1);

    // Freeze at pcnt=2 for 10 cycles; refresh keeps pulsing.
    run_edges(2);
    run = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      edge1();
      chk("frozen_time", w_now, 16'h0200);
      chk("frozen_sec_tick", sec_tick, 1'b0);
      chk("frozen_refresh", refresh, (n_edge % 3 == 0));
    end
    inc_min = 1'b1;
    edge1();
    inc_min = 1'b0;
    chk("inc_stopped_time", w_now, 16'h0300);
    chk("inc_stopped_wrap", wrap, 1'b0);
    run = 1'b1;
    edge1();
    chk("resume1_sec_tick", sec_tick, 1'b0);
    edge1();
    chk("resume2_sec_tick", sec_tick, 1'b1);
    chk("resume_time", w_now, 16'h0301);

    // Clear (with inc_min) on the tick edge at 12:34.
    clear = 1'b1; run = 1'b0;
    edge1();
    clear = 1'b0; inc_min = 1'b1;
    run_edges(12);
    inc_min = 1'b0;
    chk("t1200_time", w_now, 16'h1200);
    run = 1'b1;
    run_edges(136);
    chk("t1234_time", w_now, 16'h1234);
    run_edges(3);
    clear = 1'b1; inc_min = 1'b1;
    edge1();
    clear = 1'b0; inc_min = 1'b0;
    chk("clr_tick_time", w_now, 16'h0000);
    chk("clr_tick_sec_tick", sec_tick, 1'b0);
    chk("clr_tick_wrap", wrap, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      edge1();
      chk("post_clr_sec_tick", sec_tick, (k == 4));
    end
    chk("post_clr_time", w_now, 16'h0001);

    // Asynchronous reset between edges at 05:07.
    clear = 1'b1; run = 1'b0;
    edge1();
    clear = 1'b0; inc_min = 1'b1;
    run_edges(5);
    inc_min = 1'b0; run = 1'b1;
    run_edges(28);
    chk("t0507_time", w_now, 16'h0507);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_time", w_now, 16'h0000);
    chk("mid_rst_sec_tick", sec_tick, 1'b0);
    chk("mid_rst_wrap", wrap, 1'b0);
    chk("mid_rst_refresh", refresh, 1'b0);
    #1 rst_n = 1'b1;
    n_edge = 0;
    for (int k = 1; k <= 4; k++) begin
      edge1();
      chk("rerun_sec_tick", sec_tick, (k == 4));
      chk("rerun_refresh", refresh, (k % 3 == 0));
    end
    chk("rerun_time", w_now, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/time_counter.md
TIME_COUNTER -- requirements
Module: time_counter

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000; ck cycles per one-second step, SHALL be >= 2.
REQ-002 Parameter REFRESH_DIV, default 100_000; ck cycles between refresh pulses, SHALL be >= 2.
REQ-003 ck  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 run  input  1  level; 1 = prescaler counts, 0 = time frozen.
REQ-006 clear  input  1  synchronous; 1 = time and prescaler to zero on the next edge.
REQ-007 inc_min  input  1  synchronous single-cycle pulse; adds one minute.
REQ-008 seg0  output  4  seconds units, BCD 0-9.
REQ-009 seg1  output  4  seconds tens, BCD 0-5.
REQ-010 seg2  output  4  minutes units, BCD 0-9.
REQ-011 seg3  output  4  minutes tens, BCD 0-5.
REQ-012 refresh  output  1  one-cycle strobe that advances the downstream display digit select.
REQ-013 sec_tick  output  1  one-cycle strobe, high in the cycle the seconds advanced.
REQ-014 wrap  output  1  one-cycle strobe, high in the cycle time rolled 59:59 -> 00:00.

Function
REQ-015 All outputs SHALL be registered; no combinational input-to-output paths.
REQ-016 Prescaler pcnt SHALL count 0..TICK_DIV-1 while run=1 and hold while run=0.
REQ-017 On an edge with run=1 and pcnt=TICK_DIV-1: pcnt->0, time +1 s, sec_tick=1 for the following cycle; otherwise sec_tick=0.
REQ-018 Seconds increment: seg0 9->0 with carry to seg1; seg1 5->0 with carry to minutes; no other digit changes.
REQ-019 Minute increment: seg2 9->0 with carry to seg3; seg3 5->0 with no further carry.
REQ-020 The step from 59:59 SHALL give 00:00 with wrap=1 for one cycle, coincident with sec_tick.
REQ-021 inc_min=1 SHALL add one minute (mod 60) on that edge, leave seconds and pcnt unchanged, and never assert wrap.
REQ-022 inc_min coincident with a seconds carry into minutes SHALL add two minutes mod 60 (58->00, 59->01); wrap SHALL assert only if the seconds step alone wraps 59:59.
REQ-023 inc_min SHALL act regardless of run.
REQ-024 clear=1 SHALL load 00:00 and pcnt=0 on that edge. clear SHALL take priority over tick and inc_min, and sec_tick and wrap SHALL be 0 for the following cycle.
REQ-025 Refresh counter rcnt SHALL run free 0..REFRESH_DIV-1, independent of run, clear and inc_min; refresh=1 for one cycle after each rcnt=REFRESH_DIV-1 edge.
REQ-026 Digits SHALL never hold a non-BCD value or a tens value above 5.

Reset
REQ-027 rst_n=0 SHALL immediately, without a clock edge, force seg0..seg3=0, pcnt=0, rcnt=0, refresh=0, sec_tick=0 and wrap=0.
REQ-028 After rst_n rises, the first sec_tick SHALL occur TICK_DIV run-enabled edges later, and the first refresh REFRESH_DIV edges later.
REQ-029 Reset asserted mid-count SHALL discard prescaler progress; there is no partial-second carry-over.

Verification (TICK_DIV=4, REFRESH_DIV=3)
REQ-030 Release reset with run=1 -> sec_tick on edges 4, 8, 12; refresh on edges 3, 6, 9; seg0 reads 1, 2, 3.
REQ-031 Preload 59:58 via clear plus inc_min and ticks, then run 8 edges -> 59:59 then 00:00, with wrap and sec_tick both high in the same single cycle.
REQ-032 Hold time at 00:59 and pulse inc_min on the tick edge -> 02:00, wrap=0.
REQ-033 Drop run to 0 at pcnt=2 for 10 cycles, then restore -> time frozen and refresh still pulsing every 3; next sec_tick 2 edges after run returns.
REQ-034 Assert clear on the tick edge at 12:34 -> 00:00, sec_tick=0, next sec_tick 4 edges later.
REQ-035 Pulse rst_n low between edges at 05:07 -> all outputs 0 before the next edge.
